// File: rtl/mesh_link_buffer_if.sv
// Link bundle between mesh_link_buffer and its neighbours: upstream si/di/ri and
// downstream so/dout/ro, plus per-channel occupancy and the terminated-edge drop count.
interface mesh_link_buffer_if #(
    parameter int PACKET_WIDTH = 64,
    parameter int NUM_CH       = 4,
    parameter int DEPTH        = 2
);
    localparam int OW = $clog2(DEPTH) + 1;

    // Handshake: a flit moves on channel k at a rising clk edge exactly when the
    // sender's valid (si/so) and the receiver's ready (ri/ro) are both 1 on that edge.
    logic [NUM_CH-1:0]              si;
    logic [NUM_CH*PACKET_WIDTH-1:0] di;
    logic [NUM_CH-1:0]              ri;
    logic [NUM_CH-1:0]              so;
    logic [NUM_CH*PACKET_WIDTH-1:0] dout;
    logic [NUM_CH-1:0]              ro;
    logic [NUM_CH*OW-1:0]           occ;
    logic [15:0]                    drop_cnt;

    // master is the surrounding fabric: it drives upstream flits and downstream ready.
    modport master (output si, di, ro, input ri, so, dout, occ, drop_cnt);
    modport slave  (input si, di, ro, output ri, so, dout, occ, drop_cnt);
endinterface

// File: rtl/mesh_link_buffer.sv
// Per-channel link stage: MODE 0 wires through, MODE 1 buffers DEPTH flits per
// channel with a registered ready, MODE 2 sinks every flit and counts the drops.
module mesh_link_buffer #(
    parameter int PACKET_WIDTH = 64,
    parameter int NUM_CH       = 4,
    parameter int DEPTH        = 2,
    parameter int MODE         = 1
) (
    input logic               clk,
    input logic               reset,
    mesh_link_buffer_if.slave link
);
    localparam int OW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);

    if (MODE == 1) begin : g_buffered
        localparam logic [OW-1:0] FULL = OW'(DEPTH);

        logic [PACKET_WIDTH-1:0] mem_q    [NUM_CH][DEPTH];
        logic [PACKET_WIDTH-1:0] mem_d    [NUM_CH][DEPTH];
        logic [PW-1:0]           wr_ptr_q [NUM_CH];
        logic [PW-1:0]           wr_ptr_d [NUM_CH];
        logic [PW-1:0]           rd_ptr_q [NUM_CH];
        logic [PW-1:0]           rd_ptr_d [NUM_CH];
        logic [OW-1:0]           occ_q    [NUM_CH];
        logic [OW-1:0]           occ_d    [NUM_CH];
        logic [NUM_CH-1:0]       push;
        logic [NUM_CH-1:0]       pop;

        logic [NUM_CH-1:0]              ri_c;
        logic [NUM_CH-1:0]              so_c;
        logic [NUM_CH*PACKET_WIDTH-1:0] do_c;
        logic [NUM_CH*OW-1:0]           occ_c;

        always_comb begin
            push     = '0;
            pop      = '0;
            mem_d    = mem_q;
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            occ_d    = occ_q;
            for (int k = 0; k < NUM_CH; k++) begin
                // push qualifies on registered occupancy, so ri never sees ro
                push[k] = link.si[k] && (occ_q[k] != FULL);
                pop[k]  = link.ro[k] && (occ_q[k] != '0);
                if (push[k]) begin
                    mem_d[k][wr_ptr_q[k]] = link.di[k*PACKET_WIDTH +: PACKET_WIDTH];
                    wr_ptr_d[k]           = wr_ptr_q[k] + 1'b1;
                end
                if (pop[k]) begin
                    rd_ptr_d[k] = rd_ptr_q[k] + 1'b1;
                end
                if (push[k] && !pop[k]) begin
                    occ_d[k] = occ_q[k] + 1'b1;
                end else if (pop[k] && !push[k]) begin
                    occ_d[k] = occ_q[k] - 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    wr_ptr_q[k] <= '0;
                    rd_ptr_q[k] <= '0;
                    occ_q[k]    <= '0;
                    for (int e = 0; e < DEPTH; e++) begin
                        mem_q[k][e] <= '0;
                    end
                end
            end else begin
                mem_q    <= mem_d;
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                occ_q    <= occ_d;
            end
        end

        // Empty channels present zero data so nothing stale leaks downstream.
        always_comb begin
            ri_c  = '0;
            so_c  = '0;
            do_c  = '0;
            occ_c = '0;
            for (int k = 0; k < NUM_CH; k++) begin
                ri_c[k]             = (occ_q[k] != FULL);
                so_c[k]             = (occ_q[k] != '0);
                occ_c[k*OW +: OW]   = occ_q[k];
                if (so_c[k]) begin
                    do_c[k*PACKET_WIDTH +: PACKET_WIDTH] = mem_q[k][rd_ptr_q[k]];
                end
            end
        end

        assign link.ri       = ri_c;
        assign link.so       = so_c;
        assign link.dout     = do_c;
        assign link.occ      = occ_c;
        assign link.drop_cnt = '0;

    end else if (MODE == 2) begin : g_terminated
        logic [15:0] drop_cnt_q;
        logic [15:0] drop_cnt_d;
        logic [16:0] sum;

        // One spare bit catches the carry so the count saturates instead of wrapping.
        always_comb begin
            sum = {1'b0, drop_cnt_q};
            for (int k = 0; k < NUM_CH; k++) begin
                sum = sum + {16'd0, link.si[k]};
            end
            drop_cnt_d = sum[16] ? 16'hFFFF : sum[15:0];
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                drop_cnt_q <= '0;
            end else begin
                drop_cnt_q <= drop_cnt_d;
            end
        end

        assign link.ri       = '1;
        assign link.so       = '0;
        assign link.dout     = '0;
        assign link.occ      = '0;
        assign link.drop_cnt = drop_cnt_q;

    end else begin : g_bypass
        assign link.ri       = link.ro;
        assign link.so       = link.si;
        assign link.dout     = link.di;
        assign link.occ      = '0;
        assign link.drop_cnt = '0;
    end
endmodule

// File: doc/mesh_link_buffer.md
MESH_LINK_BUFFER -- requirements
Module: mesh_link_buffer

Interface
- REQ-001: The block SHALL have parameter PACKET_WIDTH, default 64, giving the flit width in bits.
- REQ-002: The block SHALL have parameter NUM_CH, default 4, giving the number of independent link channels (range 1..16).
- REQ-003: The block SHALL have parameter DEPTH, default 2, giving per-channel FIFO entries (power of two, >= 2).
- REQ-004: The block SHALL have parameter MODE, default 1, with values 0 = bypass, 1 = buffered, 2 = terminated edge.
- REQ-005: The block SHALL have localparam OW = log2(DEPTH)+1.
- REQ-006: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-007: reset  input  1  asynchronous, active-low reset.
- REQ-008: si  input  NUM_CH  upstream send, one bit per channel.
- REQ-009: di  input  NUM_CH*PACKET_WIDTH  upstream data; channel k occupies di[k*PACKET_WIDTH +: PACKET_WIDTH].
- REQ-010: ri  output  NUM_CH  ready to upstream.
- REQ-011: so  output  NUM_CH  downstream send.
- REQ-012: do  output  NUM_CH*PACKET_WIDTH  downstream data, sliced the same way as di.
- REQ-013: ro  input  NUM_CH  downstream ready.
- REQ-014: occ  output  NUM_CH*OW  per-channel occupancy; channel k occupies occ[k*OW +: OW].
- REQ-015: drop_cnt  output  16  count of flits sunk in terminated mode.

Function
- REQ-016: Channels SHALL be fully independent; no arbitration between channels.
- REQ-017: A push on channel k SHALL occur when si[k] && ri[k] at a rising edge.
- REQ-018: A pop on channel k SHALL occur when so[k] && ro[k] at a rising edge.
- REQ-019: MODE 1: ri[k] SHALL equal (occ_k != DEPTH), registered-state derived only, with no combinational path from ro.
- REQ-020: MODE 1: so[k] SHALL equal (occ_k != 0), and do slice k SHALL present the FIFO head, held stable while so[k] && !ro[k].
- REQ-021: MODE 1: push-to-so latency SHALL be exactly 1 cycle; no same-cycle bypass when empty.
- REQ-022: MODE 1: a simultaneous push and pop on a non-full, non-empty channel SHALL leave occ unchanged and preserve FIFO order.
- REQ-023: MODE 1: when full, ri SHALL be 0 even if ro=1 in that cycle; the pop occurs and ri rises the next cycle.
- REQ-024: MODE 1: read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
- REQ-025: MODE 1: occ SHALL increment on push-only, decrement on pop-only, and hold otherwise; it never exceeds DEPTH or underflows.
- REQ-026: MODE 0: so=si, do=di, ri=ro combinationally; occ SHALL be 0 and no flit state is held.
- REQ-027: MODE 2: ri SHALL be all ones, so=0, do=0, occ=0; every si[k] pulse SHALL be accepted and discarded.
- REQ-028: MODE 2: drop_cnt SHALL add popcount(si) each cycle, saturating at 16'hFFFF.
- REQ-029: In modes 0 and 1, drop_cnt SHALL be 0.
- REQ-030: MODE SHALL be elaboration-time only; no run-time mode change.

Reset
- REQ-031: On reset low, the block SHALL immediately clear all pointers, occ, drop_cnt, and FIFO head registers to 0, and drive so=0 (modes 1 and 2).
- REQ-032: Reset asserted mid-operation SHALL discard all buffered flits; no flit appears on do after reset release without a new push.
- REQ-033: After reset release in MODE 1, ri SHALL be all ones from the first clock edge.

Verification
- REQ-034: The bench SHALL cover: MODE 1, DEPTH=2, ro=0; push A, B on ch0 -> occ0 0->1->2, ri[0]=0 after 2 edges, so[0]=1 with do0=A stable.
- REQ-035: The bench SHALL cover: MODE 1, full ch0, then ro[0]=1 with si[0]=1 -> first edge pops A only (no push), ri[0]=1 next cycle, order A,B,C preserved.
- REQ-036: The bench SHALL cover: MODE 1, DEPTH=4, continuous si=ro=1 for 20 flits of incrementing data -> occ steady at 1, output sequence identical, pointers wrap 5 times.
- REQ-037: The bench SHALL cover: MODE 2, NUM_CH=4, si=4'b1011 for 3 cycles -> drop_cnt=9; preload 16'hFFFE then si=4'b1111 -> drop_cnt=16'hFFFF held.
- REQ-038: The bench SHALL cover: MODE 1, 2 flits buffered on ch1, reset pulsed low mid-cycle -> so[1]=0 and occ1=0 asynchronously, no stale flit after release.
- REQ-039: The bench SHALL cover: MODE 0, drive di=64'hDEAD_BEEF on ch2 with si[2]=1, toggle ro -> so/do mirror si/di and ri mirrors ro in the same cycle.
